// File: rtl/cache_cmd_scheduler.sv
// Two-port command scheduler in front of a single-outstanding cache: arbitrates
// processor vs snoop requests, issues one cache command at a time, keeps hit/miss stats.
module cache_cmd_scheduler #(
    parameter int ADDR_W     = 32,
    parameter int CNT_W      = 32,
    parameter int STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              p_valid,
    output logic              p_ready,
    input  logic [3:0]        p_cmd,
    input  logic [ADDR_W-1:0] p_addr,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [3:0]        s_cmd,
    input  logic [ADDR_W-1:0] s_addr,
    output logic              c_valid,
    output logic [3:0]        c_cmd,
    output logic [ADDR_W-1:0] c_addr,
    input  logic              c_ready,
    input  logic              c_done,
    input  logic              c_hit,
    output logic [CNT_W-1:0]  rd_cnt,
    output logic [CNT_W-1:0]  wr_cnt,
    output logic [CNT_W-1:0]  hit_cnt,
    output logic [CNT_W-1:0]  miss_cnt,
    output logic              stat_print,
    output logic              busy
);

    localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } state_t;

    state_t            state;
    logic [SW-1:0]     starve_cnt;
    logic              starved;
    logic              grant_p;
    logic              grant_s;
    logic              accept;
    logic [3:0]        req_cmd;
    logic [ADDR_W-1:0] req_addr;
    logic              done_rd;
    logic              done_wr;

    // Snoop normally wins; once the processor has waited STARVE_MAX grants it goes first.
    // Readies are gated by rst_n so nothing looks accepted while reset is held.
    always_comb begin
        starved  = p_valid && (starve_cnt == STARVE_LIM);
        grant_s  = rst_n && (state == IDLE) && s_valid && !starved;
        grant_p  = rst_n && (state == IDLE) && p_valid && !grant_s;
        accept   = grant_s || grant_p;
        req_cmd  = grant_s ? s_cmd : p_cmd;
        req_addr = grant_s ? s_addr : p_addr;
    end

    assign p_ready = grant_p;
    assign s_ready = grant_s;
    assign busy    = (state != IDLE);

    assign done_rd = (c_cmd == 4'd0) || (c_cmd == 4'd2);
    assign done_wr = (c_cmd == 4'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            starve_cnt <= '0;
            c_valid    <= 1'b0;
            c_cmd      <= '0;
            c_addr     <= '0;
            rd_cnt     <= '0;
            wr_cnt     <= '0;
            hit_cnt    <= '0;
            miss_cnt   <= '0;
            stat_print <= 1'b0;
        end else begin
            stat_print <= 1'b0;

            if (grant_s && p_valid) begin
                if (starve_cnt != STARVE_LIM) begin
                    starve_cnt <= starve_cnt + 1'b1;
                end
            end else if (grant_p) begin
                starve_cnt <= '0;
            end

            case (state)
                IDLE: begin
                    if (accept) begin
                        if (!req_cmd[3]) begin
                            c_cmd   <= req_cmd;
                            c_addr  <= req_addr;
                            c_valid <= 1'b1;
                            state   <= ISSUE;
                        end else if (req_cmd == 4'd8) begin
                            rd_cnt   <= '0;
                            wr_cnt   <= '0;
                            hit_cnt  <= '0;
                            miss_cnt <= '0;
                        end else if (req_cmd == 4'd9) begin
                            stat_print <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (c_ready) begin
                        c_valid <= 1'b0;
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    // Only reads and writes feed the statistics; other commands just retire.
                    if (c_done) begin
                        state <= IDLE;
                        if (done_rd && rd_cnt != CNT_MAX) begin
                            rd_cnt <= rd_cnt + 1'b1;
                        end
                        if (done_wr && wr_cnt != CNT_MAX) begin
                            wr_cnt <= wr_cnt + 1'b1;
                        end
                        if (done_rd || done_wr) begin
                            if (c_hit) begin
                                if (hit_cnt != CNT_MAX) begin
                                    hit_cnt <= hit_cnt + 1'b1;
                                end
                            end else if (miss_cnt != CNT_MAX) begin
                                miss_cnt <= miss_cnt + 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cache_cmd_scheduler.sv
// Directed bench for cache_cmd_scheduler; counters built 4 bits wide so saturation is reachable.
module tb_cache_cmd_scheduler;

    localparam int AW = 32;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          p_valid = 1'b0;
    logic          p_ready;
    logic [3:0]    p_cmd = '0;
    logic [AW-1:0] p_addr = '0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [3:0]    s_cmd = '0;
    logic [AW-1:0] s_addr = '0;
    logic          c_valid;
    logic [3:0]    c_cmd;
    logic [AW-1:0] c_addr;
    logic          c_ready = 1'b0;
    logic          c_done = 1'b0;
    logic          c_hit = 1'b0;
    logic [CW-1:0] rd_cnt;
    logic [CW-1:0] wr_cnt;
    logic [CW-1:0] hit_cnt;
    logic [CW-1:0] miss_cnt;
    logic          stat_print;
    logic          busy;

    int total = 0;
    int bad = 0;

    cache_cmd_scheduler #(
        .ADDR_W(AW),
        .CNT_W(CW),
        .STARVE_MAX(3)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .p_valid(p_valid),
        .p_ready(p_ready),
        .p_cmd(p_cmd),
        .p_addr(p_addr),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .s_cmd(s_cmd),
        .s_addr(s_addr),
        .c_valid(c_valid),
        .c_cmd(c_cmd),
        .c_addr(c_addr),
        .c_ready(c_ready),
        .c_done(c_done),
        .c_hit(c_hit),
        .rd_cnt(rd_cnt),
        .wr_cnt(wr_cnt),
        .hit_cnt(hit_cnt),
        .miss_cnt(miss_cnt),
        .stat_print(stat_print),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_cmd(input logic [3:0] cmd);
        p_valid = 1'b1;
        p_cmd   = cmd;
        p_addr  = 32'h0000_0040;
        step();
        p_valid = 1'b0;
    endtask

    task automatic do_read(input logic hit);
        issue_cmd(4'd0);
        c_ready = 1'b1;
        step();
        c_ready = 1'b0;
        c_done  = 1'b1;
        c_hit   = hit;
        step();
        c_done  = 1'b0;
        c_hit   = 1'b0;
    endtask

    task automatic test_reset();
        p_valid = 1'b1;
        s_valid = 1'b1;
        #3;
        total++;
        if ({p_ready, s_ready, busy, c_valid, stat_print} !== 5'b0) begin
            bad++;
            $display("[TB] FAIL reset_ctrl got=%b want=00000", {p_ready, s_ready, busy, c_valid, stat_print});
        end
        total++;
        if ({rd_cnt, wr_cnt, hit_cnt, miss_cnt, c_cmd} !== 20'h0 || c_addr !== 32'h0) begin
            bad++;
            $display("[TB] FAIL reset_regs cnt=%h cmd=%h addr=%h want=0", {rd_cnt, wr_cnt, hit_cnt, miss_cnt}, c_cmd, c_addr);
        end
        @(negedge clk);
        rst_n   = 1'b1;
        p_valid = 1'b0;
        s_valid = 1'b0;
        step();
    endtask

    task automatic test_single_read();
        p_valid = 1'b1;
        p_cmd   = 4'd0;
        p_addr  = 32'h1000_0040;
        #1;
        total++;
        if (p_ready !== 1'b1) begin
            bad++;
            $display("[TB] FAIL read_p_ready got=%b want=1", p_ready);
        end
        step();
        p_valid = 1'b0;
        total++;
        if (c_valid !== 1'b1 || c_cmd !== 4'd0 || c_addr !== 32'h1000_0040 || busy !== 1'b1) begin
            bad++;
            $display("[TB] FAIL read_issue got v=%b cmd=%h addr=%h busy=%b want 1/0/10000040/1", c_valid, c_cmd, c_addr, busy);
        end
        c_ready = 1'b1;
        step();
        c_ready = 1'b0;
        total++;
        if (c_valid !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("[TB] FAIL read_one_cycle got v=%b busy=%b want 0/1", c_valid, busy);
        end
        step();
        c_done = 1'b1;
        c_hit  = 1'b0;
        step();
        c_done = 1'b0;
        total++;
        if (rd_cnt !== 4'd1 || miss_cnt !== 4'd0 + 4'd1 || hit_cnt !== 4'd0 || busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL read_done got rd=%0d miss=%0d hit=%0d busy=%b want 1/1/0/0", rd_cnt, miss_cnt, hit_cnt, busy);
        end
    endtask

    task automatic test_back_to_back();
        logic grants[8];
        int n = 0;
        int cyc = 0;
        p_cmd   = 4'd1;
        s_cmd   = 4'd1;
        p_addr  = 32'h0000_0100;
        s_addr  = 32'h0000_0200;
        c_ready = 1'b1;
        c_done  = 1'b1;
        c_hit   = 1'b1;
        p_valid = 1'b1;
        s_valid = 1'b1;
        while (n < 8 && cyc < 60) begin
            #1;
            if (s_ready || p_ready) begin
                grants[n] = s_ready;
                n++;
            end
            step();
            cyc++;
        end
        p_valid = 1'b0;
        s_valid = 1'b0;
        total++;
        if (n != 8) begin
            bad++;
            $display("[TB] FAIL b2b_grant_count got=%0d want=8", n);
        end
        for (int i = 0; i < n; i++) begin
            total++;
            if (grants[i] !== (i % 4 != 3)) begin
                bad++;
                $display("[TB] FAIL b2b_order idx=%0d got_snoop=%b want_snoop=%b", i, grants[i], (i % 4 != 3));
            end
        end
        cyc = 0;
        while (busy && cyc < 10) begin
            step();
            cyc++;
        end
        c_ready = 1'b0;
        c_done  = 1'b0;
        c_hit   = 1'b0;
        total++;
        if (busy !== 1'b0 || wr_cnt !== 4'd8 || hit_cnt !== 4'd8 || rd_cnt !== 4'd1 || miss_cnt !== 4'd1) begin
            bad++;
            $display("[TB] FAIL b2b_counts got busy=%b wr=%0d hit=%0d rd=%0d miss=%0d want 0/8/8/1/1", busy, wr_cnt, hit_cnt, rd_cnt, miss_cnt);
        end
    endtask

    task automatic test_stall();
        p_valid = 1'b1;
        p_cmd   = 4'd2;
        p_addr  = 32'hDEAD_BEEC;
        step();
        p_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            total++;
            if (c_valid !== 1'b1 || c_cmd !== 4'd2 || c_addr !== 32'hDEAD_BEEC) begin
                bad++;
                $display("[TB] FAIL stall_hold cyc=%0d got v=%b cmd=%h addr=%h want 1/2/deadbeec", i, c_valid, c_cmd, c_addr);
            end
            step();
        end
        c_ready = 1'b1;
        c_done  = 1'b1;
        c_hit   = 1'b1;
        step();
        c_ready = 1'b0;
        c_done  = 1'b0;
        total++;
        if (c_valid !== 1'b0 || busy !== 1'b1 || rd_cnt !== 4'd1) begin
            bad++;
            $display("[TB] FAIL stall_early_done got v=%b busy=%b rd=%0d want 0/1/1", c_valid, busy, rd_cnt);
        end
        c_done = 1'b1;
        step();
        c_done = 1'b0;
        c_hit  = 1'b0;
        total++;
        if (rd_cnt !== 4'd2 || hit_cnt !== 4'd9 || busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL stall_done got rd=%0d hit=%0d busy=%b want 2/9/0", rd_cnt, hit_cnt, busy);
        end
    endtask

    task automatic test_stat_clear();
        issue_cmd(4'd8);
        total++;
        if (rd_cnt !== 4'd0 || hit_cnt !== 4'd0) begin
            bad++;
            $display("[TB] FAIL clear_first got rd=%0d hit=%0d want 0/0", rd_cnt, hit_cnt);
        end
        do_read(1'b0);
        do_read(1'b0);
        do_read(1'b0);
        issue_cmd(4'd9);
        total++;
        if (stat_print !== 1'b1 || rd_cnt !== 4'd3 || c_valid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL print_pulse got sp=%b rd=%0d v=%b busy=%b want 1/3/0/0", stat_print, rd_cnt, c_valid, busy);
        end
        step();
        total++;
        if (stat_print !== 1'b0) begin
            bad++;
            $display("[TB] FAIL print_width got=%b want=0", stat_print);
        end
        issue_cmd(4'd12);
        total++;
        if (busy !== 1'b0 || c_valid !== 1'b0 || rd_cnt !== 4'd3 || miss_cnt !== 4'd3) begin
            bad++;
            $display("[TB] FAIL drop_cmd got busy=%b v=%b rd=%0d miss=%0d want 0/0/3/3", busy, c_valid, rd_cnt, miss_cnt);
        end
        issue_cmd(4'd8);
        total++;
        if ({rd_cnt, wr_cnt, hit_cnt, miss_cnt} !== 16'h0 || c_valid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL clear_all got cnt=%h v=%b busy=%b want 0000/0/0", {rd_cnt, wr_cnt, hit_cnt, miss_cnt}, c_valid, busy);
        end
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 15; i++) begin
            do_read(1'b1);
        end
        total++;
        if (rd_cnt !== 4'hF || hit_cnt !== 4'hF) begin
            bad++;
            $display("[TB] FAIL sat_reach got rd=%h hit=%h want f/f", rd_cnt, hit_cnt);
        end
        do_read(1'b1);
        total++;
        if (rd_cnt !== 4'hF || hit_cnt !== 4'hF || miss_cnt !== 4'h0) begin
            bad++;
            $display("[TB] FAIL sat_hold got rd=%h hit=%h miss=%h want f/f/0", rd_cnt, hit_cnt, miss_cnt);
        end
    endtask

    task automatic test_reset_mid();
        p_valid = 1'b1;
        p_cmd   = 4'd1;
        p_addr  = 32'h0000_0ABC;
        step();
        p_valid = 1'b0;
        c_ready = 1'b1;
        step();
        c_ready = 1'b0;
        total++;
        if (busy !== 1'b1 || c_cmd !== 4'd1) begin
            bad++;
            $display("[TB] FAIL mid_wait got busy=%b cmd=%h want 1/1", busy, c_cmd);
        end
        #2;
        rst_n   = 1'b0;
        p_valid = 1'b1;
        p_cmd   = 4'd0;
        #1;
        total++;
        if (busy !== 1'b0 || c_valid !== 1'b0 || c_cmd !== 4'd0 || c_addr !== 32'h0 || p_ready !== 1'b0 || rd_cnt !== 4'd0 || hit_cnt !== 4'd0) begin
            bad++;
            $display("[TB] FAIL mid_async got busy=%b v=%b cmd=%h addr=%h pr=%b rd=%0d hit=%0d want all 0", busy, c_valid, c_cmd, c_addr, p_ready, rd_cnt, hit_cnt);
        end
        @(negedge clk);
        rst_n   = 1'b1;
        p_valid = 1'b0;
        c_done  = 1'b1;
        c_hit   = 1'b1;
        step();
        c_done  = 1'b0;
        c_hit   = 1'b0;
        total++;
        if (busy !== 1'b0 || {rd_cnt, wr_cnt, hit_cnt, miss_cnt} !== 16'h0) begin
            bad++;
            $display("[TB] FAIL mid_stray_done got busy=%b cnt=%h want 0/0000", busy, {rd_cnt, wr_cnt, hit_cnt, miss_cnt});
        end
        p_valid = 1'b1;
        p_addr  = 32'h0000_0080;
        #1;
        total++;
        if (p_ready !== 1'b1) begin
            bad++;
            $display("[TB] FAIL post_reset_ready got=%b want=1", p_ready);
        end
        step();
        p_valid = 1'b0;
        total++;
        if (c_valid !== 1'b1 || c_addr !== 32'h0000_0080) begin
            bad++;
            $display("[TB] FAIL post_reset_issue got v=%b addr=%h want 1/00000080", c_valid, c_addr);
        end
        c_ready = 1'b1;
        step();
        c_ready = 1'b0;
        c_done  = 1'b1;
        step();
        c_done  = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_back_to_back();
        test_stall();
        test_stat_clear();
        test_saturate();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
